fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Controller that sequences the in-place radix-2 decimation-in-time FFT over the shared sample RAM once the AXI bridge reports the samples are loaded. For every stage it issues butterfly jobs to the butterfly datapath: RAM address pair, twiddle index and stage number. It enforces a stage barrier against read-after-write hazards. When the transform completes it raises the calculation-end flag that releases the bridge into its write-out phase.

## Interface
- `ADDR_WIDTH`, 12, sample RAM address width; matches the bridge sample index.
- `MAX_LOG2`, 11, largest supported log2(N); N max is 2048.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_DATA_LOADED`  in  1  start request from the bridge; sampled only in IDLE.
- `i_SAMPLES_NUMBER`  in  12  transform length N; latched on an accepted start.
- `i_BF_READY`  in  1  butterfly unit accepts a job this cycle.
- `i_BF_DONE`  in  1  one-cycle pulse per butterfly whose results are written back to RAM.
- `o_BF_VALID`  out  1  job presented on the address and twiddle outputs.
- `o_ADDR_A`  out  12  upper-wing address (A).
- `o_ADDR_B`  out  12  lower-wing address (B = A + half).
- `o_TWIDDLE_INDEX`  out  11  exponent k of W_N^k.
- `o_STAGE`  out  4  current stage s.
- `o_BUSY`  out  1  high outside IDLE and DONE.
- `o_CALC_END`  out  1  transform complete (level).
- `o_ERROR`  out  1  sticky error flag.

## Operation
- State machine states: IDLE, CHECK, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `i_DATA_LOADED`=1: latch N, clear `o_ERROR`, go to CHECK.
- **CHECK**
  - N must be a power of two in 2..2048.
  - Invalid N: set `o_ERROR`, return to IDLE; `o_CALC_END` stays 0.
  - Valid N: L = log2(N), s = 0, k = 0, go to ISSUE.
- **ISSUE**
  - Assert `o_BF_VALID` with address outputs derived from s and k:
    - half = 1<<s.
    - j = k & (half-1).
    - A = ((k>>s)<<(s+1)) + j.
    - B = A + half.
    - twiddle = j << (L-1-s).
  - Transfer occurs when `o_BF_VALID` and `i_BF_READY` are both high at a clock edge.
    - On transfer: k increments and the outstanding counter increments.
    - Back-to-back transfers are allowed.
    - Outputs hold stable while not ready.
  - After the transfer with k = N/2-1: go to DRAIN.
- **DRAIN**
  - `o_BF_VALID` is 0; wait until the outstanding count is 0.
  - Then, if s = L-1, go to DONE.
  - Otherwise s++, k = 0, go to ISSUE.
- **DONE**
  - `o_CALC_END` = 1, held until the next accepted start or reset.
  - A new `i_DATA_LOADED` goes to CHECK and clears `o_CALC_END`.
- **Outstanding counter** (12 bit)
  - A transfer and an `i_BF_DONE` in the same cycle leave the count unchanged.
  - `i_BF_DONE` with count 0 (and no simultaneous transfer): ignored, sets `o_ERROR`; the sequence continues.
- **Other rules**
  - `i_DATA_LOADED` while busy is ignored.
  - Input data in RAM is in bit-reversed order; output is natural order. The sequencer performs no reordering.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - k, s and the outstanding count are 0.
  - Reset mid-transform aborts immediately; no `o_CALC_END`.
- Start at edge t: CHECK during t+1, first `o_BF_VALID` during t+2.
- With `i_BF_READY` held high: one butterfly per cycle; a stage issues in N/2 cycles.
- DRAIN lasts at least 1 cycle. It ends on the edge where the count reaches 0, and the next stage's first job appears the following cycle.
- DONE is entered on the cycle after the final DRAIN completes; `o_CALC_END` is registered.
- N=2: L=1; a single butterfly (0,1) with twiddle 0.

## Structure
- `fft_pkg` holds:
  - the `seq_state_t` enum (IDLE, CHECK, ISSUE, DRAIN, DONE);
  - `ADDR_WIDTH`, `MAX_LOG2` and `TW_WIDTH` = `MAX_LOG2` constants;
  - an `is_pow2` function.
- Sub-module `fft_addr_gen`: purely combinational mapping (s, k, L) -> (A, B, twiddle). The sequencer registers its outputs.
- log2 of N is computed by a priority encoder in CHECK.

## Test plan
- N=8, ready always 1, done 2 cycles after each transfer. Required issue sequence:
  - Stage 0: (0,1),(2,3),(4,5),(6,7), twiddle 0.
  - Stage 1: (0,2),(1,3),(4,6),(5,7), twiddles 0,2,0,2.
  - Stage 2: (0,4),(1,5),(2,6),(3,7), twiddles 0,1,2,3.
  - Then `o_CALC_END`=1.
- N=8 with `i_BF_READY` toggling 1/0: the same 12 jobs in order, each held stable while not ready; no duplicates or drops.
- Stage barrier: N=4, `i_BF_DONE` for the last stage-0 job delayed 10 cycles. No stage-1 `o_BF_VALID` appears before that done pulse arrives.
- N=12 and N=4096(=0): `o_ERROR`=1 at CHECK+1, state IDLE, `o_CALC_END`=0. Then N=2 completes normally with `o_ERROR` cleared.
- `i_rst`=1 mid stage 1 of N=16: all outputs 0 on the next cycle. A subsequent start reissues from stage 0, job (0,1).
- Spurious `i_BF_DONE` in IDLE sets `o_ERROR`. `i_DATA_LOADED` pulsed during ISSUE has no effect on the job sequence.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT stage sequencer.
package fft_pkg;

  localparam int ADDR_WIDTH  = 12;
  localparam int MAX_LOG2    = 11;
  localparam int TW_WIDTH    = MAX_LOG2;
  localparam int STAGE_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  function automatic logic is_pow2(input logic [ADDR_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address/twiddle mapping for stage s, job k, log2 length l.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [STAGE_WIDTH-1:0] s,
  input  logic [ADDR_WIDTH-2:0]  k,
  input  logic [STAGE_WIDTH-1:0] l,
  output logic [ADDR_WIDTH-1:0]  addr_a,
  output logic [ADDR_WIDTH-1:0]  addr_b,
  output logic [TW_WIDTH-1:0]    twiddle
);

  logic [ADDR_WIDTH-1:0] half;
  logic [ADDR_WIDTH-1:0] k_ext;
  logic [ADDR_WIDTH-1:0] j;
  logic [ADDR_WIDTH-1:0] tw_full;

  always_comb begin
    half    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << s;
    k_ext   = {1'b0, k};
    j       = k_ext & (half - 1'b1);
    addr_a  = ((k_ext >> s) << (s + 4'd1)) + j;
    addr_b  = addr_a + half;
    // l-1-s is never negative while a job is being issued; other values are masked upstream
    tw_full = j << (l - 4'd1 - s);
    twiddle = tw_full[TW_WIDTH-1:0];
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT job sequencer with a per-stage drain barrier.
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_DATA_LOADED,
  input  logic [ADDR_WIDTH-1:0]  i_SAMPLES_NUMBER,
  input  logic                   i_BF_READY,
  input  logic                   i_BF_DONE,
  output logic                   o_BF_VALID,
  output logic [ADDR_WIDTH-1:0]  o_ADDR_A,
  output logic [ADDR_WIDTH-1:0]  o_ADDR_B,
  output logic [TW_WIDTH-1:0]    o_TWIDDLE_INDEX,
  output logic [STAGE_WIDTH-1:0] o_STAGE,
  output logic                   o_BUSY,
  output logic                   o_CALC_END,
  output logic                   o_ERROR
);

  seq_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0]  n_reg, n_nxt, cnt, cnt_nxt;
  logic [ADDR_WIDTH-2:0]  k, k_nxt;
  logic [STAGE_WIDTH-1:0] s, s_nxt, l, l_nxt, n_log2;
  logic err_nxt, err_set, calc_nxt;
  logic xfer, last_job, n_ok;
  logic [ADDR_WIDTH-1:0]  gen_a, gen_b;
  logic [TW_WIDTH-1:0]    gen_tw;

  assign xfer     = o_BF_VALID & i_BF_READY;
  assign last_job = ({1'b0, k} == ((n_reg >> 1) - 1'b1));
  assign n_ok     = is_pow2(n_reg) && !n_reg[0];
  assign o_BUSY   = (state == ST_CHECK) || (state == ST_ISSUE) || (state == ST_DRAIN);
  assign o_STAGE  = s;

  always_comb begin
    n_log2 = '0;
    for (int i = 0; i < ADDR_WIDTH; i++)
      if (n_reg[i]) n_log2 = STAGE_WIDTH'(i);
  end

  // Outputs are registered from the next-state view so a job appears the cycle its state is entered.
  fft_addr_gen u_addr_gen (
    .s      (s_nxt),
    .k      (k_nxt),
    .l      (l_nxt),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .twiddle(gen_tw)
  );

  always_comb begin
    state_nxt = state;
    n_nxt     = n_reg;
    k_nxt     = k;
    s_nxt     = s;
    l_nxt     = l;
    err_nxt   = o_ERROR;
    err_set   = 1'b0;
    calc_nxt  = o_CALC_END;
    cnt_nxt   = cnt;

    if (xfer && !i_BF_DONE)
      cnt_nxt = cnt + 1'b1;
    else if (!xfer && i_BF_DONE) begin
      if (cnt == '0) err_set = 1'b1;
      else           cnt_nxt = cnt - 1'b1;
    end

    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_DATA_LOADED) begin
          n_nxt     = i_SAMPLES_NUMBER;
          err_nxt   = 1'b0;
          calc_nxt  = 1'b0;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (n_ok) begin
          l_nxt     = n_log2;
          s_nxt     = '0;
          k_nxt     = '0;
          state_nxt = ST_ISSUE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          if (last_job) begin
            k_nxt     = '0;
            state_nxt = ST_DRAIN;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_nxt == '0) begin
          if (s == l - 4'd1) begin
            calc_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            s_nxt     = s + 4'd1;
            k_nxt     = '0;
            state_nxt = ST_ISSUE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (err_set) err_nxt = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      n_reg           <= '0;
      cnt             <= '0;
      k               <= '0;
      s               <= '0;
      l               <= '0;
      o_BF_VALID      <= 1'b0;
      o_ADDR_A        <= '0;
      o_ADDR_B        <= '0;
      o_TWIDDLE_INDEX <= '0;
      o_CALC_END      <= 1'b0;
      o_ERROR         <= 1'b0;
    end else begin
      state           <= state_nxt;
      n_reg           <= n_nxt;
      cnt             <= cnt_nxt;
      k               <= k_nxt;
      s               <= s_nxt;
      l               <= l_nxt;
      o_BF_VALID      <= (state_nxt == ST_ISSUE);
      o_ADDR_A        <= (state_nxt == ST_ISSUE) ? gen_a : '0;
      o_ADDR_B        <= (state_nxt == ST_ISSUE) ? gen_b : '0;
      o_TWIDDLE_INDEX <= (state_nxt == ST_ISSUE) ? gen_tw : '0;
      o_CALC_END      <= calc_nxt;
      o_ERROR         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench: butterfly-unit responder plus a loop-based FFT job reference.
module tb_fft_stage_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_DATA_LOADED = 1'b0;
  logic [11:0] i_SAMPLES_NUMBER = '0;
  logic        i_BF_READY = 1'b0;
  logic        i_BF_DONE = 1'b0;
  logic        o_BF_VALID;
  logic [11:0] o_ADDR_A, o_ADDR_B;
  logic [10:0] o_TWIDDLE_INDEX;
  logic [3:0]  o_STAGE;
  logic        o_BUSY, o_CALC_END, o_ERROR;

  fft_stage_sequencer dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_DATA_LOADED   (i_DATA_LOADED),
    .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER),
    .i_BF_READY      (i_BF_READY),
    .i_BF_DONE       (i_BF_DONE),
    .o_BF_VALID      (o_BF_VALID),
    .o_ADDR_A        (o_ADDR_A),
    .o_ADDR_B        (o_ADDR_B),
    .o_TWIDDLE_INDEX (o_TWIDDLE_INDEX),
    .o_STAGE         (o_STAGE),
    .o_BUSY          (o_BUSY),
    .o_CALC_END      (o_CALC_END),
    .o_ERROR         (o_ERROR)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // job word: {stage, twiddle, A, B}
  logic [38:0] got[$];
  logic [38:0] hold_job;
  bit          hold_v = 0;
  int          pend[256];
  int          cyc = 0;
  int          rdy_mode = 0;
  int          dly_min = 2, dly_max = 2;
  int          special_idx = -1, special_delay = 0, special_done = -1;
  int          first_s1 = -1;
  int          stall_err = 0;

  // Butterfly responder: picks ready, records transfers, schedules done pulses.
  always @(negedge i_clk) begin
    int slot, d;
    bit r;
    logic [38:0] job;
    cyc++;
    slot = cyc % 256;
    if (i_rst) begin
      i_BF_READY = 1'b0;
      i_BF_DONE  = 1'b0;
    end else begin
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      i_BF_READY = r;
      if (o_BF_VALID) begin
        if (o_STAGE == 4'd1 && first_s1 < 0) first_s1 = cyc;
        job = {o_STAGE, o_TWIDDLE_INDEX, o_ADDR_A, o_ADDR_B};
        if (hold_v && job !== hold_job) stall_err++;
        if (r) begin
          if (got.size() == special_idx) begin
            d = special_delay;
            special_done = cyc + d;
          end else begin
            d = $urandom_range(dly_min, dly_max);
          end
          got.push_back(job);
          pend[(cyc + d) % 256]++;
          hold_v = 0;
        end else begin
          hold_v   = 1;
          hold_job = job;
        end
      end else begin
        hold_v = 0;
      end
      i_BF_DONE = (pend[slot] > 0);
      if (pend[slot] > 1) pend[(slot + 1) % 256] += pend[slot] - 1;
      pend[slot] = 0;
    end
  end

  // Reference: enumerate butterflies by stage, group and wing offset.
  function automatic int seq_diff(int n);
    logic [38:0] exp_q[$];
    int lg, half, tw, a, bad;
    lg = $clog2(n);
    for (int st = 0; st < lg; st++) begin
      half = 1 << st;
      for (int g = 0; g < n / (2 * half); g++)
        for (int j = 0; j < half; j++) begin
          a  = g * 2 * half + j;
          tw = j * (n / (2 * half));
          exp_q.push_back({4'(st), 11'(tw), 12'(a), 12'(a + half)});
        end
    end
    bad = (exp_q.size() == got.size()) ? 0 : 1;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (exp_q[i] !== got[i]) begin
        if (bad < 4) $display("  job %0d observed %h reference %h", i, got[i], exp_q[i]);
        bad++;
      end
    return bad;
  endfunction

  task automatic prep(int mode, int dmin, int dmax);
    got.delete();
    rdy_mode = mode; dly_min = dmin; dly_max = dmax;
    special_idx = -1; special_done = -1; first_s1 = -1; stall_err = 0;
  endtask

  task automatic start(int n);
    @(negedge i_clk);
    i_DATA_LOADED    = 1'b1;
    i_SAMPLES_NUMBER = n[11:0];
    @(negedge i_clk);
    i_DATA_LOADED    = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 3000; i++) begin
      if (o_CALC_END || o_ERROR) begin timed_out = 0; break; end
      @(negedge i_clk);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 256; i++) pend[i] = 0;
    hold_v = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    do_reset();
    obs = {o_BF_VALID, o_ADDR_A, o_ADDR_B, o_TWIDDLE_INDEX, o_STAGE, o_BUSY, o_CALC_END, o_ERROR};
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", obs); end
  endtask

  task automatic test_n8_ready_high();
    bit to; int bad;
    prep(0, 2, 2);
    start(8);
    checks++;
    if ({o_BUSY, o_BF_VALID} !== 2'b10) begin
      failures++; $display("FAIL check_cycle: busy/valid %b expected 10", {o_BUSY, o_BF_VALID});
    end
    @(negedge i_clk);
    checks++;
    if ({o_BF_VALID, o_ADDR_A, o_ADDR_B, o_TWIDDLE_INDEX} !== {1'b1, 12'd0, 12'd1, 11'd0}) begin
      failures++; $display("FAIL first_job: valid=%b A=%0d B=%0d tw=%0d expected 1,0,1,0",
                           o_BF_VALID, o_ADDR_A, o_ADDR_B, o_TWIDDLE_INDEX);
    end
    wait_end(to);
    checks++;
    if (to) begin failures++; $display("FAIL n8_timeout: no calc_end"); end
    bad = seq_diff(8);
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL n8_sequence: %0d bad jobs expected 0", bad); end
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_CALC_END, o_BUSY, o_ERROR} !== 3'b100) begin
      failures++; $display("FAIL n8_done_flags: end/busy/err %b expected 100", {o_CALC_END, o_BUSY, o_ERROR});
    end
  endtask

  task automatic test_ready_toggle();
    bit to; int bad;
    prep(1, 2, 2);
    start(8);
    wait_end(to);
    bad = seq_diff(8);
    checks++;
    if (to || bad !== 0) begin
      failures++; $display("FAIL toggle_sequence: timeout=%0d bad=%0d expected 0,0", to, bad);
    end
    checks++;
    if (stall_err !== 0) begin failures++; $display("FAIL toggle_hold: %0d changes expected 0", stall_err); end
  endtask

  task automatic test_random();
    bit to; int bad, n;
    for (int it = 0; it < 6; it++) begin
      n = 1 << $urandom_range(1, 6);
      prep(2, 1, 5);
      start(n);
      wait_end(to);
      bad = seq_diff(n);
      checks++;
      if (to || bad !== 0 || stall_err !== 0 || o_ERROR !== 1'b0) begin
        failures++;
        $display("FAIL random_n%0d: timeout=%0d bad=%0d stalls=%0d err=%b expected 0,0,0,0",
                 n, to, bad, stall_err, o_ERROR);
      end
    end
  endtask

  task automatic test_barrier();
    bit to; int bad;
    prep(0, 2, 2);
    special_idx = 1; special_delay = 10;
    start(4);
    wait_end(to);
    bad = seq_diff(4);
    checks++;
    if (to || bad !== 0) begin failures++; $display("FAIL barrier_sequence: timeout=%0d bad=%0d expected 0,0", to, bad); end
    checks++;
    if (first_s1 !== special_done + 1) begin
      failures++; $display("FAIL barrier_stage1_cycle: got %0d expected %0d", first_s1, special_done + 1);
    end
  endtask

  task automatic test_invalid();
    bit to; int bad;
    int bad_n[2] = '{12, 4096};
    foreach (bad_n[i]) begin
      prep(0, 2, 2);
      start(bad_n[i]);
      @(negedge i_clk);
      checks++;
      if ({o_ERROR, o_BUSY, o_CALC_END, o_BF_VALID} !== 4'b1000) begin
        failures++; $display("FAIL invalid_n%0d: err/busy/end/valid %b expected 1000",
                             bad_n[i], {o_ERROR, o_BUSY, o_CALC_END, o_BF_VALID});
      end
    end
    prep(0, 2, 2);
    start(2);
    wait_end(to);
    bad = seq_diff(2);
    checks++;
    if (to || bad !== 0 || {o_CALC_END, o_ERROR} !== 2'b10) begin
      failures++; $display("FAIL n2_after_error: timeout=%0d bad=%0d end/err=%b expected 0,0,10",
                           to, bad, {o_CALC_END, o_ERROR});
    end
  endtask

  task automatic test_reset_mid();
    bit to, seen; int bad;
    logic [41:0] obs;
    prep(0, 2, 2);
    start(16);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge i_clk);
      if (o_BF_VALID && o_STAGE == 4'd1) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL reset_mid_reach_stage1: got 0 expected 1"); end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    obs = {o_BF_VALID, o_ADDR_A, o_ADDR_B, o_TWIDDLE_INDEX, o_STAGE, o_BUSY, o_CALC_END, o_ERROR};
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_mid_outputs: got %h expected 0", obs); end
    for (int i = 0; i < 256; i++) pend[i] = 0;
    hold_v = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    prep(0, 2, 2);
    start(16);
    wait_end(to);
    bad = seq_diff(16);
    checks++;
    if (to || bad !== 0 || got.size() == 0 || got[0] !== {4'd0, 11'd0, 12'd0, 12'd1}) begin
      failures++; $display("FAIL reset_mid_restart: timeout=%0d bad=%0d expected 0,0", to, bad);
    end
  endtask

  task automatic test_spurious_and_busy_start();
    bit to; int bad;
    do_reset();
    prep(0, 2, 2);
    #1;
    pend[(cyc + 1) % 256]++;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_ERROR, o_BUSY} !== 2'b10) begin
      failures++; $display("FAIL spurious_done: err/busy %b expected 10", {o_ERROR, o_BUSY});
    end
    prep(1, 1, 3);
    start(8);
    repeat (2) @(negedge i_clk);
    i_DATA_LOADED = 1'b1; i_SAMPLES_NUMBER = 12'd4;
    @(negedge i_clk);
    i_DATA_LOADED = 1'b0;
    wait_end(to);
    bad = seq_diff(8);
    checks++;
    if (to || bad !== 0 || o_ERROR !== 1'b0) begin
      failures++; $display("FAIL start_while_busy: timeout=%0d bad=%0d err=%b expected 0,0,0", to, bad, o_ERROR);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pend[i] = 0;
    test_reset();
    test_n8_ready_high();
    test_ready_toggle();
    test_random();
    test_barrier();
    test_invalid();
    test_reset_mid();
    test_spurious_and_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
